// File: rtl/wt_cache_pkg.sv
// Shared dcache geometry and the hit-update record used by the replacement feeder.
package wt_cache_pkg;

  localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
  localparam int unsigned DCACHE_SET_ASSOC    = 4;
  localparam int unsigned DCACHE_WAY_WIDTH    = $clog2(DCACHE_SET_ASSOC);
  localparam int unsigned HIT_FIFO_DEPTH      = 4;

  typedef struct packed {
    logic                           valid;
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_WAY_WIDTH-1:0]    way;
  } repl_hit_t;

endpackage

// File: rtl/wt_dcache_repl_fifo.sv
// Hit update buffer: multi-push, single-pop circular buffer with an
// associative duplicate search and victim purge over the stored entries.
module wt_dcache_repl_fifo
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned Depth    = HIT_FIFO_DEPTH,
  localparam int unsigned PtrW    = $clog2(Depth),
  localparam int unsigned CntW    = $clog2(Depth + 1)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          flush_i,
  input  logic                                          pop_i,
  input  logic [NumPorts-1:0]                           push_i,
  input  logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0]  push_idx_i,
  input  logic [NumPorts-1:0][DCACHE_WAY_WIDTH-1:0]     push_way_i,
  input  logic                                          purge_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0]                purge_idx_i,
  input  logic [DCACHE_WAY_WIDTH-1:0]                   purge_way_i,
  output logic [NumPorts-1:0]                           match_o,
  output repl_hit_t                                     head_o,
  output logic [CntW-1:0]                               count_o
);

  repl_hit_t           mem_q [Depth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     count_q;
  logic [CntW-1:0]     n_push;
  logic [PtrW-1:0]     wr_slot [NumPorts];

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // Pack accepted pushes into consecutive slots starting at the write pointer.
  always_comb begin
    n_push = '0;
    for (int p = 0; p < NumPorts; p++) begin
      wr_slot[p] = wptr_q + PtrW'(n_push);
      if (push_i[p]) n_push = n_push + CntW'(1);
    end
  end

  // Duplicate search of each incoming hit against all live entries.
  always_comb begin
    match_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      for (int i = 0; i < Depth; i++) begin
        if (mem_q[i].valid && mem_q[i].idx == push_idx_i[p] && mem_q[i].way == push_way_i[p])
          match_o[p] = 1'b1;
      end
    end
  end

  // Buffer state: purge, pop (clears the slot so free slots never look live), then writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (purge_i && mem_q[i].idx == purge_idx_i && mem_q[i].way == purge_way_i)
          mem_q[i].valid <= 1'b0;
      end
      if (pop_i) begin
        mem_q[rptr_q].valid <= 1'b0;
        rptr_q              <= rptr_q + PtrW'(1);
      end
      for (int p = 0; p < NumPorts; p++) begin
        if (push_i[p]) mem_q[wr_slot[p]] <= '{valid: 1'b1, idx: push_idx_i[p], way: push_way_i[p]};
      end
      wptr_q  <= wptr_q + PtrW'(n_push);
      count_q <= count_q - CntW'(pop_i) + n_push;
    end
  end

endmodule

// File: rtl/wt_dcache_repl_arb.sv
// Feeds the NRU replacement array: misses pass straight through with priority,
// read-port hits are deduplicated, buffered and replayed one per idle cycle.
module wt_dcache_repl_arb
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts     = 3,
  parameter int unsigned HitFifoDepth = HIT_FIFO_DEPTH,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          flush_i,
  input  logic [NumPorts-1:0]                           hit_valid_i,
  input  logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0]  hit_idx_i,
  input  logic [NumPorts-1:0][DCACHE_WAY_WIDTH-1:0]     hit_way_i,
  input  logic                                          miss_req_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0]                miss_idx_i,
  output logic [DCACHE_WAY_WIDTH-1:0]                   miss_way_o,
  output logic                                          nru_hit_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]                nru_hit_idx_o,
  output logic [DCACHE_WAY_WIDTH-1:0]                   nru_hit_way_o,
  output logic                                          nru_miss_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]                nru_miss_idx_o,
  input  logic [DCACHE_WAY_WIDTH-1:0]                   nru_way_i,
  output logic                                          fifo_full_o,
  output logic [DropCntWidth-1:0]                       drop_cnt_o
);

  localparam int unsigned CntW  = $clog2(HitFifoDepth + 1);
  localparam int unsigned DropW = $clog2(NumPorts + 1);

  logic [NumPorts-1:0] match, enq;
  repl_hit_t           head;
  logic [CntW-1:0]     count, free, n_enq;
  logic [DropW-1:0]    n_drop;
  logic                pop, dup, victim;
  logic [DropCntWidth-1:0] drop_cnt_q;
  logic [DropCntWidth:0]   drop_sum;

  assign nru_miss_o     = miss_req_i;
  assign nru_miss_idx_o = miss_idx_i;
  assign miss_way_o     = nru_way_i;

  assign pop            = !miss_req_i && (count != '0);
  assign nru_hit_o      = pop && head.valid;
  assign nru_hit_idx_o  = nru_hit_o ? head.idx : '0;
  assign nru_hit_way_o  = nru_hit_o ? head.way : '0;
  assign fifo_full_o    = (count == CntW'(HitFifoDepth));
  assign drop_cnt_o     = drop_cnt_q;

  // Port scan: discard duplicates and victim hits, enqueue into free slots, count the rest as drops.
  always_comb begin
    enq    = '0;
    n_enq  = '0;
    n_drop = '0;
    dup    = 1'b0;
    victim = 1'b0;
    free   = CntW'(HitFifoDepth) - count + CntW'(pop);
    for (int p = 0; p < NumPorts; p++) begin
      dup = match[p];
      for (int q = 0; q < p; q++) begin
        if (hit_valid_i[q] && hit_idx_i[q] == hit_idx_i[p] && hit_way_i[q] == hit_way_i[p])
          dup = 1'b1;
      end
      victim = miss_req_i && hit_idx_i[p] == miss_idx_i && hit_way_i[p] == nru_way_i;
      if (hit_valid_i[p] && !dup && !victim && !flush_i) begin
        if (n_enq < free) begin
          enq[p] = 1'b1;
          n_enq  = n_enq + CntW'(1);
        end else begin
          n_drop = n_drop + DropW'(1);
        end
      end
    end
  end

  assign drop_sum = {1'b0, drop_cnt_q} + (DropCntWidth + 1)'(n_drop);

  // Saturating dropped-hit counter; survives flush, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      drop_cnt_q <= '0;
    else if (drop_sum[DropCntWidth])  drop_cnt_q <= '1;
    else                              drop_cnt_q <= drop_sum[DropCntWidth-1:0];
  end

  wt_dcache_repl_fifo #(
    .NumPorts (NumPorts),
    .Depth    (HitFifoDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .pop_i       (pop),
    .push_i      (enq),
    .push_idx_i  (hit_idx_i),
    .push_way_i  (hit_way_i),
    .purge_i     (miss_req_i),
    .purge_idx_i (miss_idx_i),
    .purge_way_i (nru_way_i),
    .match_o     (match),
    .head_o      (head),
    .count_o     (count)
  );

endmodule
